multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Parametrised multi-cycle RV32I control unit; successor to the single-cycle R-type decoder. FSM sequences FETCH/DECODE/EXECUTE/MEM/WB over R, I-ALU, LOAD, STORE, BRANCH, JAL and JALR, and drives the datapath enables. Handshakes with data memory via dmem_ready with a wait-timeout. Sits between the instruction register and the existing datapath (regfile, ALU, PC, data memory).

Parameters:
ALU_OP_W, 4, width of aluOP; encoding fixed in the package, values 0..9.
MEM_TIMEOUT, 15, maximum MEM-state cycles with dmem_ready low before trap; must be >=1.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
instrCode  input  32  instruction from IR; stable from DECODE until the next FETCH
dmem_ready  input  1  data memory completes the current access this cycle
irWe  output  1  latch instruction into IR
pcEn  output  1  PC update strobe, one cycle per retired instruction
regFileWe  output  1  register file write enable
aluOP  output  ALU_OP_W  ALU operation
aluSrcMuxSel  output  1  0 = rs2, 1 = immediate
rfWdSel  output  2  write-back select: 0 = ALU, 1 = memory, 2 = PC+4
dataRe  output  1  data memory read request
dataWe  output  1  data memory write request
branch  output  1  B-type in EXECUTE; datapath qualifies it with the compare result
jump  output  1  JAL/JALR target select, EXECUTE only
illegal  output  1  sticky trap flag

Behaviour:
- Reset (async, active-high): state=FETCH, timeout counter=0, illegal=0, every output 0, aluOP=ADD(0). Reset in any state, including mid-MEM, aborts the instruction without any write.
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP. Outputs are a function of state and instrCode only (Moore plus decode), with no combinational path from dmem_ready except pcEn in MEM.
- FETCH: irWe=1 -> DECODE.
- DECODE: opcode checked. Legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111 and 1100111; legal -> EXECUTE. Anything else -> TRAP.
- EXECUTE:
  - aluOP valid. aluSrcMuxSel=1 for I/LOAD/STORE/JALR.
  - R and I -> WB. LOAD and STORE -> MEM.
  - BRANCH: branch=1, pcEn=1 -> FETCH.
  - JAL and JALR: jump=1 -> WB.
- MEM:
  - LOAD holds dataRe=1; STORE holds dataWe=1.
  - dmem_ready=1: LOAD -> WB; STORE asserts pcEn=1 -> FETCH. Zero-wait ready on MEM entry is allowed.
  - Counter increments each ready-low cycle. When the counter reaches MEM_TIMEOUT -> TRAP with no pcEn. Counter clears on MEM exit.
- WB: regFileWe=1, pcEn=1, -> FETCH. rfWdSel: R/I=0, LOAD=1, JAL/JALR=2.
- TRAP: illegal=1, all enables 0, held until reset.
- Instruction latencies:
  - R/I and JAL/JALR: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4+waits cycles.
  - LOAD: 5+waits cycles.
- aluOP encoding: ADD0 SUB1 SLL2 SRL3 SRA4 SLT5 SLTU6 XOR7 OR8 AND9.
  - R-type: {instr[30], funct3} mapping.
  - I-ALU: {0, funct3}, except funct3=101 uses instr[30] (SRLI/SRAI); ADDI never yields SUB.
  - LOAD/STORE/JAL/JALR: ADD.
  - BRANCH: BEQ/BNE=SUB, BLT/BGE=SLT, BLTU/BGEU=SLTU.
  - Unlisted R-type {instr[30], funct3} combination: in DECODE -> TRAP.
- regFileWe is never asserted outside WB. dataRe and dataWe are never asserted outside MEM.

Decomposition:
- Package cu_pkg holds:
  - state_t enum
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR)
  - ALU_* aluOP localparams
  - RFWD_ALU/MEM/PC4 constants
- Sub-module alu_decoder: combinational opcode/funct3/instr[30] -> aluOP plus an r_illegal flag.
- FSM, timeout counter and output decode stay in the top level.

Test Plan:
- ADD 0x002081B3 after reset -> irWe at cycle 0; aluOP=0 and aluSrcMuxSel=0 at cycle 2; regFileWe=1, rfWdSel=0 and pcEn=1 at cycle 3 only; FETCH at cycle 4.
- SRAI 0x4020D193 -> aluOP=4, aluSrcMuxSel=1 in EXECUTE; ADDI 0x40008193 (bit30 set) -> aluOP=0.
- LW 0x0000A183 with dmem_ready low for 3 MEM cycles then high -> dataRe=1 for 4 cycles; WB next cycle with rfWdSel=1 and regFileWe=1.
- SW 0x0030A023 with dmem_ready never asserted -> dataWe held for 15 cycles, then illegal=1, TRAP, pcEn never pulses.
- Opcode 0x0000007F -> TRAP after DECODE; illegal=1 and stays 1 for 20 cycles; regFileWe, dataWe and pcEn stay 0.
- reset asserted mid-MEM of LW -> all outputs 0 immediately (async), illegal=0; after release irWe=1 on the first clock.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg
// Shared types and constants for the multi-cycle RV32I control unit:
//   state_t     - control FSM states
//   OP_*        - major opcodes (instr[6:0]) the unit accepts
//   ALU_*       - aluOP encoding understood by the datapath ALU
//   RFWD_*      - register-file write-back source select
// -----------------------------------------------------------------------------
package cu_pkg;

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_TRAP    = 3'd5
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SRL  = 4'd3;
   localparam logic [3:0] ALU_SRA  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_XOR  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam logic [1:0] RFWD_ALU = 2'd0;
   localparam logic [1:0] RFWD_MEM = 2'd1;
   localparam logic [1:0] RFWD_PC4 = 2'd2;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_if
// Bundle between the control unit and the datapath.
//   master (control unit): in  instrCode, dmem_ready
//                          out irWe, pcEn, regFileWe, aluOP, aluSrcMuxSel,
//                              rfWdSel, dataRe, dataWe, branch, jump, illegal
//   slave  (datapath/IR/memory side): the mirror image
// -----------------------------------------------------------------------------
interface multicycle_control_unit_if #(
   parameter int ALU_OP_W = 4
);
   logic [31:0]         instrCode;
   logic                dmem_ready;
   logic                irWe;
   logic                pcEn;
   logic                regFileWe;
   logic [ALU_OP_W-1:0] aluOP;
   logic                aluSrcMuxSel;
   logic [1:0]          rfWdSel;
   logic                dataRe;
   logic                dataWe;
   logic                branch;
   logic                jump;
   logic                illegal;

   modport master (
      input  instrCode, dmem_ready,
      output irWe, pcEn, regFileWe, aluOP, aluSrcMuxSel, rfWdSel,
             dataRe, dataWe, branch, jump, illegal
   );

   modport slave (
      output instrCode, dmem_ready,
      input  irWe, pcEn, regFileWe, aluOP, aluSrcMuxSel, rfWdSel,
             dataRe, dataWe, branch, jump, illegal
   );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational ALU operation decode.
//   opcode    in  instr[6:0]
//   funct3    in  instr[14:12]
//   bit30     in  instr[30] (SUB/SRA/SRAI selector)
//   aluop     out ALU operation (cu_pkg ALU_* encoding)
//   r_illegal out R-type {bit30,funct3} pair with no RV32I meaning
// -----------------------------------------------------------------------------
module alu_decoder
   import cu_pkg::*;
#(
   parameter int ALU_OP_W = 4
) (
   input  logic [6:0]          opcode,
   input  logic [2:0]          funct3,
   input  logic                bit30,
   output logic [ALU_OP_W-1:0] aluop,
   output logic                r_illegal
);

   logic [3:0] code;

   always_comb begin
      code      = ALU_ADD;
      r_illegal = 1'b0;
      case (opcode)
         OP_R: begin
            case ({bit30, funct3})
               4'b0000: code = ALU_ADD;
               4'b1000: code = ALU_SUB;
               4'b0001: code = ALU_SLL;
               4'b0101: code = ALU_SRL;
               4'b1101: code = ALU_SRA;
               4'b0010: code = ALU_SLT;
               4'b0011: code = ALU_SLTU;
               4'b0100: code = ALU_XOR;
               4'b0110: code = ALU_OR;
               4'b0111: code = ALU_AND;
               default: r_illegal = 1'b1;
            endcase
         end
         OP_I: begin
            // bit30 is part of the immediate here, so it only matters for
            // the shift-right pair; ADDI with bit30 set stays ADD.
            case (funct3)
               3'b000:  code = ALU_ADD;
               3'b001:  code = ALU_SLL;
               3'b010:  code = ALU_SLT;
               3'b011:  code = ALU_SLTU;
               3'b100:  code = ALU_XOR;
               3'b101:  code = bit30 ? ALU_SRA : ALU_SRL;
               3'b110:  code = ALU_OR;
               default: code = ALU_AND;
            endcase
         end
         OP_BRANCH: begin
            case (funct3[2:1])
               2'b10:   code = ALU_SLT;
               2'b11:   code = ALU_SLTU;
               default: code = ALU_SUB;
            endcase
         end
         default: code = ALU_ADD;
      endcase
   end

   assign aluop = ALU_OP_W'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB plus a sticky
// TRAP state for illegal opcodes and data-memory timeouts.
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-high reset
//   bus    master modport of multicycle_control_unit_if (IR input,
//          dmem_ready, and all datapath enables/selects)
// -----------------------------------------------------------------------------
module multicycle_control_unit
   import cu_pkg::*;
#(
   parameter int ALU_OP_W    = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                       clk,
   input  logic                       reset,
   multicycle_control_unit_if.master  bus
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;

   logic [6:0]          opcode;
   logic [ALU_OP_W-1:0] dec_aluop;
   logic                r_illegal;
   logic                op_legal;
   logic                unused_instr_bits;

   logic                ir_we, pc_en, rf_we, alu_src, data_re, data_we;
   logic                br, jmp, trap;
   logic [1:0]          rf_wd_sel;
   logic [ALU_OP_W-1:0] alu_op;

   assign opcode            = bus.instrCode[6:0];
   assign unused_instr_bits = ^{bus.instrCode[31], bus.instrCode[29:15],
                                bus.instrCode[11:7]};

   alu_decoder #(.ALU_OP_W(ALU_OP_W)) u_alu_decoder (
      .opcode    (opcode),
      .funct3    (bus.instrCode[14:12]),
      .bit30     (bus.instrCode[30]),
      .aluop     (dec_aluop),
      .r_illegal (r_illegal)
   );

   always_comb begin
      case (opcode)
         OP_R:                              op_legal = !r_illegal;
         OP_I, OP_LOAD, OP_STORE,
         OP_BRANCH, OP_JAL, OP_JALR:        op_legal = 1'b1;
         default:                           op_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_FETCH;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      ir_we      = 1'b0;
      pc_en      = 1'b0;
      rf_we      = 1'b0;
      alu_src    = 1'b0;
      data_re    = 1'b0;
      data_we    = 1'b0;
      br         = 1'b0;
      jmp        = 1'b0;
      trap       = 1'b0;
      rf_wd_sel  = RFWD_ALU;
      alu_op     = ALU_OP_W'(ALU_ADD);

      case (state_reg)
         S_FETCH: begin
            ir_we      = 1'b1;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            state_next = op_legal ? S_EXECUTE : S_TRAP;
         end
         S_EXECUTE: begin
            alu_op  = dec_aluop;
            alu_src = (opcode == OP_I) || (opcode == OP_LOAD) ||
                      (opcode == OP_STORE) || (opcode == OP_JALR);
            case (opcode)
               OP_R, OP_I:        state_next = S_WB;
               OP_LOAD, OP_STORE: state_next = S_MEM;
               OP_BRANCH: begin
                  br         = 1'b1;
                  pc_en      = 1'b1;
                  state_next = S_FETCH;
               end
               OP_JAL, OP_JALR: begin
                  jmp        = 1'b1;
                  state_next = S_WB;
               end
               default:           state_next = S_TRAP;
            endcase
         end
         S_MEM: begin
            data_re = (opcode == OP_LOAD);
            data_we = (opcode != OP_LOAD);
            if (bus.dmem_ready) begin
               cnt_next = '0;
               if (opcode == OP_LOAD) begin
                  state_next = S_WB;
               end else begin
                  pc_en      = 1'b1;
                  state_next = S_FETCH;
               end
            end else if (cnt_reg == CNT_W'(MEM_TIMEOUT - 1)) begin
               // This ready-low cycle is the MEM_TIMEOUT-th one; trap now
               // rather than spending a cycle storing the terminal count.
               cnt_next   = '0;
               state_next = S_TRAP;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         S_WB: begin
            rf_we = 1'b1;
            pc_en = 1'b1;
            case (opcode)
               OP_LOAD:         rf_wd_sel = RFWD_MEM;
               OP_JAL, OP_JALR: rf_wd_sel = RFWD_PC4;
               default:         rf_wd_sel = RFWD_ALU;
            endcase
            state_next = S_FETCH;
         end
         S_TRAP: begin
            trap = 1'b1;
         end
         default: begin
            state_next = S_FETCH;
         end
      endcase
   end

   // While reset is held the state already reads FETCH; gating keeps irWe
   // (and everything else) low until reset is actually released.
   assign bus.irWe         = ir_we   & ~reset;
   assign bus.pcEn         = pc_en   & ~reset;
   assign bus.regFileWe    = rf_we   & ~reset;
   assign bus.aluSrcMuxSel = alu_src & ~reset;
   assign bus.dataRe       = data_re & ~reset;
   assign bus.dataWe       = data_we & ~reset;
   assign bus.branch       = br      & ~reset;
   assign bus.jump         = jmp     & ~reset;
   assign bus.illegal      = trap    & ~reset;
   assign bus.rfWdSel      = reset ? RFWD_ALU : rf_wd_sel;
   assign bus.aluOP        = reset ? ALU_OP_W'(ALU_ADD) : alu_op;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
   import cu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_control_unit_if #(.ALU_OP_W(4)) bus ();

   multicycle_control_unit #(.ALU_OP_W(4), .MEM_TIMEOUT(15)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total  = 0;
   int passed = 0;

   logic [14:0] outs;
   assign outs = {bus.irWe, bus.pcEn, bus.regFileWe, bus.dataRe, bus.dataWe,
                  bus.branch, bus.jump, bus.illegal, bus.aluSrcMuxSel,
                  bus.rfWdSel, bus.aluOP};

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      if (obs !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      else
         passed++;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Holds reset across one rising edge, checks outputs are all low, then
   // releases; the caller is left in the first FETCH cycle.
   task automatic apply_reset(input string tag);
      reset = 1'b1;
      bus.dmem_ready = 1'b0;
      tick();
      check({tag, "_rst_outs"}, 32'(outs), 32'h0);
      reset = 1'b0;
      #1;
   endtask

   // R / I / JAL / JALR: FETCH, DECODE, EXECUTE, WB.
   task automatic run_alu(input string tag, input logic [31:0] instr,
                          input logic [3:0] exp_op, input logic exp_src,
                          input logic exp_jump, input logic [1:0] exp_wd);
      bus.instrCode = instr;
      #1;
      check({tag, "_irwe"}, 32'(bus.irWe), 32'h1);
      tick();
      check({tag, "_decode_outs"}, 32'(outs), 32'h0);
      tick();
      check({tag, "_aluop"}, 32'(bus.aluOP), 32'(exp_op));
      check({tag, "_alusrc"}, 32'(bus.aluSrcMuxSel), 32'(exp_src));
      check({tag, "_jump"}, 32'(bus.jump), 32'(exp_jump));
      check({tag, "_ex_rfwe"}, 32'(bus.regFileWe), 32'h0);
      tick();
      check({tag, "_wb_rfwe"}, 32'(bus.regFileWe), 32'h1);
      check({tag, "_wb_wdsel"}, 32'(bus.rfWdSel), 32'(exp_wd));
      check({tag, "_wb_pcen"}, 32'(bus.pcEn), 32'h1);
      tick();
      check({tag, "_next_fetch"}, 32'({bus.irWe, bus.pcEn, bus.regFileWe}), 32'b100);
      $display("txn %s instr=%08h done", tag, instr);
   endtask

   // FETCH, DECODE, then stop at EXECUTE after checking aluOP/aluSrcMuxSel.
   task automatic to_execute(input string tag, input logic [31:0] instr,
                             input logic [3:0] exp_op, input logic exp_src);
      bus.instrCode = instr;
      #1;
      check({tag, "_irwe"}, 32'(bus.irWe), 32'h1);
      tick();
      tick();
      check({tag, "_aluop"}, 32'(bus.aluOP), 32'(exp_op));
      check({tag, "_alusrc"}, 32'(bus.aluSrcMuxSel), 32'(exp_src));
   endtask

   task automatic run_load(input string tag, input int waits);
      int re_cnt = 0;
      int pc_seen = 0;
      to_execute(tag, 32'h0000A183, 4'd0, 1'b1);
      tick();
      for (int i = 0; i <= waits; i++) begin
         bus.dmem_ready = (i == waits);
         #1;
         if (bus.dataRe) re_cnt++;
         if (bus.pcEn)   pc_seen++;
         tick();
      end
      bus.dmem_ready = 1'b0;
      #1;
      check({tag, "_datare_cycles"}, 32'(re_cnt), 32'(waits + 1));
      check({tag, "_mem_pcen"}, 32'(pc_seen), 32'h0);
      check({tag, "_wb_rfwe"}, 32'(bus.regFileWe), 32'h1);
      check({tag, "_wb_wdsel"}, 32'(bus.rfWdSel), 32'(RFWD_MEM));
      check({tag, "_wb_pcen"}, 32'(bus.pcEn), 32'h1);
      check({tag, "_wb_datare"}, 32'(bus.dataRe), 32'h0);
      tick();
      check({tag, "_next_fetch"}, 32'(bus.irWe), 32'h1);
      $display("txn %s waits=%0d done", tag, waits);
   endtask

   initial begin
      int we_cnt;
      int pc_seen;
      int bad;

      bus.instrCode  = 32'h0;
      bus.dmem_ready = 1'b0;
      apply_reset("init");
      check("init_fetch_irwe", 32'(bus.irWe), 32'h1);

      // R/I/jump group
      run_alu("add",  32'h002081B3, ALU_ADD, 1'b0, 1'b0, RFWD_ALU);
      run_alu("sub",  32'h402081B3, ALU_SUB, 1'b0, 1'b0, RFWD_ALU);
      run_alu("srai", 32'h4020D193, ALU_SRA, 1'b1, 1'b0, RFWD_ALU);
      run_alu("addi", 32'h40008193, ALU_ADD, 1'b1, 1'b0, RFWD_ALU);
      run_alu("jal",  32'h0000006F, ALU_ADD, 1'b0, 1'b1, RFWD_PC4);
      run_alu("jalr", 32'h00008067, ALU_ADD, 1'b1, 1'b1, RFWD_PC4);

      // BLT: 3 cycles, branch+pcEn in EXECUTE
      to_execute("blt", 32'h0020C463, ALU_SLT, 1'b0);
      check("blt_branch", 32'(bus.branch), 32'h1);
      check("blt_pcen", 32'(bus.pcEn), 32'h1);
      tick();
      check("blt_next_fetch", 32'(bus.irWe), 32'h1);
      $display("txn blt done");

      // Loads: three waits, and zero-wait
      run_load("lw_w3", 3);
      run_load("lw_w0", 0);

      // Zero-wait store
      to_execute("sw0", 32'h0030A023, ALU_ADD, 1'b1);
      tick();
      bus.dmem_ready = 1'b1;
      #1;
      check("sw0_datawe", 32'(bus.dataWe), 32'h1);
      check("sw0_pcen", 32'(bus.pcEn), 32'h1);
      check("sw0_rfwe", 32'(bus.regFileWe), 32'h0);
      tick();
      bus.dmem_ready = 1'b0;
      #1;
      check("sw0_next_fetch", 32'(bus.irWe), 32'h1);
      $display("txn sw0 done");

      // Store timeout: dataWe for 15 cycles then TRAP, no pcEn
      to_execute("sw_to", 32'h0030A023, ALU_ADD, 1'b1);
      tick();
      we_cnt = 0;
      pc_seen = 0;
      for (int i = 0; i < 40 && !bus.illegal; i++) begin
         if (bus.dataWe) we_cnt++;
         if (bus.pcEn)   pc_seen++;
         tick();
      end
      check("sw_to_datawe_cycles", 32'(we_cnt), 32'd15);
      check("sw_to_pcen", 32'(pc_seen), 32'h0);
      check("sw_to_illegal", 32'(bus.illegal), 32'h1);
      check("sw_to_trap_datawe", 32'(bus.dataWe), 32'h0);
      $display("txn sw_timeout done");
      apply_reset("sw_to");

      // Illegal opcode: sticky trap for 20 cycles
      bus.instrCode = 32'h0000007F;
      tick();
      tick();
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (!bus.illegal || bus.regFileWe || bus.dataWe || bus.pcEn) bad++;
         tick();
      end
      check("ill_op_trap_cycles_bad", 32'(bad), 32'h0);
      check("ill_op_illegal", 32'(bus.illegal), 32'h1);
      $display("txn illegal_opcode done");
      apply_reset("ill_op");

      // Unlisted R-type pair {1,001} traps after DECODE
      bus.instrCode = 32'h40209033;
      tick();
      tick();
      check("ill_r_illegal", 32'(bus.illegal), 32'h1);
      $display("txn illegal_rtype done");
      apply_reset("ill_r");

      // Async reset mid-MEM of a load
      to_execute("lw_rst", 32'h0000A183, ALU_ADD, 1'b1);
      tick();
      tick();
      check("lw_rst_in_mem", 32'(bus.dataRe), 32'h1);
      #2;
      reset = 1'b1;
      #1;
      check("lw_rst_async_outs", 32'(outs), 32'h0);
      tick();
      check("lw_rst_held_outs", 32'(outs), 32'h0);
      reset = 1'b0;
      #1;
      check("lw_rst_release_irwe", 32'(bus.irWe), 32'h1);
      tick();
      check("lw_rst_decode_outs", 32'(outs), 32'h0);
      $display("txn reset_mid_mem done");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
